p_mul_seq: RTL
==============

# p_mul_seq

Parametrised multi-cycle packed multiplier for the XCrypto packed-SIMD datapath. It accepts one 32-bit operand pair per request and supports all five pack widths (32/16/8/4/2), both integer and carry-less (clmul) modes, and low- or high-half result selection. The operation is iterative shift-add, retiring `BPC` multiplier bits per cycle. It sits behind the same valid/ready request interface as the other `p_*` functional units.

## Interface
- `BPC`, default 1: multiplier bits retired per cycle. Legal values are 1, 2, 4 and 8.
- `clock`  in  1: sole clock.
- `resetn`  in  1: reset, asynchronous, active-low.
- `valid`  in  1: request valid. Held high with stable inputs until `ready`.
- `ready`  out  1: one-cycle pulse. `result` is valid in the same cycle.
- `mul_l`  in  1: return the low halves of the products.
- `mul_h`  in  1: return the high halves of the products.
- `clmul`  in  1: 1 = carry-less (GF(2)) multiply; 0 = unsigned integer multiply.
- `pw`  in  5: one-hot pack width. Bit 0 = 32, bit 1 = 16, bit 2 = 8, bit 3 = 4, bit 4 = 2.
- `crs1`  in  32: multiplicand lanes.
- `crs2`  in  32: multiplier lanes.
- `result`  out  32: registered result.

## Operation
- Lane width is W ∈ {32, 16, 8, 4, 2}, giving L = 32/W lanes.
- For each lane i, P_i = a_i × b_i, a 2W-bit product. `clmul` makes this an XOR-accumulate with no carries.
- Every product is unsigned. No carry crosses a lane boundary.
- 64-bit accumulator layout:
  - acc[31:0] = {P_{L-1}[W-1:0], …, P_0[W-1:0]}.
  - acc[63:32] = {P_{L-1}[2W-1:W], …, P_0[2W-1:W]}.
- Result selection:
  - `mul_l` set: result = acc[31:0]. `mul_l` takes priority over `mul_h`.
  - Else `mul_h` set: result = acc[63:32].
  - Neither set: result = 0.
- When the request is accepted, `crs1`, `crs2`, `pw`, `clmul`, `mul_l` and `mul_h` are captured into internal registers. Later changes to the inputs have no effect.
- Step count N = max(1, W/BPC). All lanes advance in parallel.
- Each step takes the next BPC bits of every lane of b, LSB first. It forms the partial products of the lane's a, shifted to the current bit position, and adds or XORs them into that lane's 2W-bit accumulator slice.
- Illegal `pw` (zero or multi-hot): N = 1, result = 0, and the normal handshake completes.
- FSM states and transitions:
  - IDLE → BUSY when `valid`=1. Inputs are captured, the accumulator is cleared and the counter is set to N.
  - BUSY → IDLE when `valid`=0 (abort). No `ready` is produced and the accumulator is discarded.
  - BUSY → DONE when the counter reaches its last step. `result` is registered on this transition.
  - DONE → IDLE unconditionally. `ready`=1 during DONE.
- Reset values:
  - State = IDLE.
  - `ready` = 0.
  - `result` = 0.
  - Accumulator and counter = 0.
- A reset mid-operation returns all of the above to their reset values asynchronously.

## Timing
- The request is accepted at edge 0, when `valid` is sampled high in IDLE.
- BUSY occupies cycles 1..N. `ready`=1 in cycle N+1 only.
- Total latency is N+1 cycles. Example: `BPC`=1, pw=32 gives 33 cycles; pw=2 gives 3 cycles.
- `result` holds its value after `ready` until the next completion.
- Back-to-back: if `valid` is still high in the cycle after DONE, a new request is accepted there. Issue interval is N+2 cycles.
- The requester samples `result` on `valid && ready`.
- `valid` falling in the DONE cycle has no effect: completion has already happened.

## Structure
- Package `p_mul_pkg`:
  - one-hot `pw` bit indices and widths;
  - FSM state enum {IDLE, BUSY, DONE};
  - lane-count and step-count helper functions.
- Sub-module `p_mul_step` (combinational): given a, the BPC-bit multiplier slices, the bit offset, W and `clmul`, it returns the 64-bit lane-masked partial-sum increment with carries killed at 2W slice boundaries.
- The top level holds the FSM, counter, operand and accumulator registers, and the result mux.

## Test plan
- pw=32, `mul_l`, crs1=crs2=0xFFFFFFFF, `BPC`=1 → result=0x00000001 with `ready` in cycle 33. Same request with `mul_h` → 0xFFFFFFFE.
- pw=16, integer, crs1=0xFFFF0003, crs2=0x00020005:
  - `mul_l` → 0xFFFE000F.
  - `mul_h` → 0x00010000.
- pw=8, clmul, crs1=crs2=0x03030303:
  - `mul_l` → 0x05050505.
  - `mul_h` → 0x00000000.
  - Repeat with pw=4, crs1=0xFFFFFFFF, crs2=0x11111111, `mul_l` → 0xFFFFFFFF.
- Abort and reset:
  - Drop `valid` at BUSY cycle 5 → `ready` never pulses and state returns to IDLE. A following pw=32 request of 7×9 completes with 0x0000003F.
  - Assert `resetn` low mid-BUSY → `ready`=0 and `result`=0 immediately.
- Illegal `pw` and back-to-back:
  - pw=5'b00011 → `ready` in cycle 2, result 0.
  - Keep `valid` high across DONE → the second request is accepted with an N+2 issue interval.
- Randomised run of 10k requests for each `BPC` ∈ {1, 2, 4, 8}:
  - all pw, `clmul`, `mul_l` and `mul_h` combinations, including random aborts;
  - every `result` checked against a combinational reference model on `valid && ready`.

Source files
------------

// File: rtl/p_mul_seq_pkg.sv
// p_mul_seq shared types: pack-width encoding, FSM states,
// lane/step helpers and accumulator unpacking.
package p_mul_pkg;

  localparam int PW_32 = 0;
  localparam int PW_16 = 1;
  localparam int PW_8  = 2;
  localparam int PW_4  = 3;
  localparam int PW_2  = 4;
  localparam int NPW   = 5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // Lane width for a one-hot pw, 0 when pw is not one-hot.
  function automatic int lane_w(input logic [4:0] pw);
    int w;
    w = 0;
    case (pw)
      5'b00001: w = 32;
      5'b00010: w = 16;
      5'b00100: w = 8;
      5'b01000: w = 4;
      5'b10000: w = 2;
      default:  w = 0;
    endcase
    return w;
  endfunction

  function automatic int lanes(input logic [4:0] pw);
    int w;
    w = lane_w(pw);
    return (w == 0) ? 0 : 32 / w;
  endfunction

  // Shift-add steps: max(1, W/BPC); illegal pw takes one step.
  function automatic logic [5:0] steps(
    input logic [4:0] pw,
    input int         bpc
  );
    int n;
    n = lane_w(pw) / bpc;
    if (n < 1) n = 1;
    return 6'(n);
  endfunction

  // The accumulator keeps lane i's 2W-bit product contiguous
  // at [2W*i +: 2W]; this regroups it into {high halves, low halves}.
  function automatic logic [63:0] unpack(
    input logic [63:0] acc,
    input logic [4:0]  pw
  );
    logic [31:0] lo;
    logic [31:0] hi;
    int          w;
    lo = '0;
    hi = '0;
    for (int k = 0; k < NPW; k++) begin
      w = 32 >> k;
      if (pw == 5'(1 << k)) begin
        for (int i = 0; i < 32; i++) begin
          lo[5'(i)] = acc[6'(2*w*(i/w) + i%w)];
          hi[5'(i)] = acc[6'(2*w*(i/w) + w + i%w)];
        end
      end
    end
    return {hi, lo};
  endfunction

endpackage

// File: rtl/p_mul_seq_if.sv
// p_mul_seq request interface: valid/ready handshake plus operands.
// master = requester, slave = multiplier.
interface p_mul_seq_if;
  logic        valid;
  logic        ready;
  logic        mul_l;
  logic        mul_h;
  logic        clmul;
  logic [4:0]  pw;
  logic [31:0] crs1;
  logic [31:0] crs2;
  logic [31:0] result;

  modport master (
    output valid, mul_l, mul_h, clmul, pw, crs1, crs2,
    input  ready, result
  );

  modport slave (
    input  valid, mul_l, mul_h, clmul, pw, crs1, crs2,
    output ready, result
  );
endinterface

// File: rtl/p_mul_seq_step.sv
// p_mul_step: one shift-add step for all lanes (combinational).
// i_a/i_b operands (b pre-shifted), i_off bit offset, o_inc increment.
module p_mul_step
  import p_mul_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_off,
  input  logic [4:0]  i_pw,
  input  logic        i_clmul,
  output logic [63:0] o_inc
);

  // Only each lane's low BPC bits of b are consumed per step.
  logic w_unused;
  assign w_unused = ^i_b;

  for (genvar k = 0; k < NPW; k++) begin : g_w
    localparam int W = 32 >> k;
    localparam int L = 32 / W;
    logic [63:0] w_inc;

    for (genvar i = 0; i < L; i++) begin : g_l
      logic [2*W-1:0] w_ps [BPC+1];
      assign w_ps[0] = '0;

      for (genvar j = 0; j < BPC; j++) begin : g_b
        if (j < W) begin : g_on
          logic           w_en;
          logic [2*W-1:0] w_pp;
          assign w_en = i_b[i*W+j]
                      && ((int'(i_off) + j) < W);
          assign w_pp = {{W{1'b0}}, i_a[i*W +: W]}
                      << (int'(i_off) + j);
          assign w_ps[j+1] =
            !w_en   ? w_ps[j] :
            i_clmul ? (w_ps[j] ^ w_pp) :
                      (w_ps[j] + w_pp);
        end else begin : g_off
          assign w_ps[j+1] = w_ps[j];
        end
      end

      assign w_inc[2*W*i +: 2*W] = w_ps[BPC];
    end
  end

  always_comb begin
    o_inc = '0;
    case (i_pw)
      5'b00001: o_inc = g_w[PW_32].w_inc;
      5'b00010: o_inc = g_w[PW_16].w_inc;
      5'b00100: o_inc = g_w[PW_8].w_inc;
      5'b01000: o_inc = g_w[PW_4].w_inc;
      5'b10000: o_inc = g_w[PW_2].w_inc;
      default:  o_inc = '0;
    endcase
  end

endmodule

// File: rtl/p_mul_seq.sv
// p_mul_seq: iterative packed multiplier, BPC bits per cycle.
// clock/resetn plain; bus carries valid/ready, operands, result.
module p_mul_seq
  import p_mul_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic       clock,
  input  logic       resetn,
  p_mul_seq_if.slave bus
);

  state_e      r_state;
  state_e      w_nxt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_result;
  logic [4:0]  r_pw;
  logic [4:0]  r_off;
  logic        r_clmul;
  logic        r_mul_l;
  logic        r_mul_h;
  logic [63:0] r_acc;
  logic [5:0]  r_cnt;
  logic [63:0] w_inc;
  logic [63:0] w_acc;
  logic [63:0] w_unp;
  logic        w_last;
  logic [31:0] w_res;

  p_mul_step #(
    .BPC(BPC)
  ) u_step (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_off  (r_off),
    .i_pw   (r_pw),
    .i_clmul(r_clmul),
    .o_inc  (w_inc)
  );

  // Lane products never exceed 2W bits, so a plain
  // 64-bit add cannot carry between lane slices.
  assign w_acc  = r_clmul ? (r_acc ^ w_inc)
                          : (r_acc + w_inc);
  assign w_last = (r_cnt == 6'd1);
  assign w_unp  = unpack(w_acc, r_pw);

  always_comb begin
    w_res = '0;
    if (r_mul_l)      w_res = w_unp[31:0];
    else if (r_mul_h) w_res = w_unp[63:32];
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: if (bus.valid) w_nxt = BUSY;
      BUSY: begin
        if (!bus.valid)  w_nxt = IDLE;
        else if (w_last) w_nxt = DONE;
      end
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_nxt;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_a      <= '0;
      r_b      <= '0;
      r_pw     <= '0;
      r_clmul  <= 1'b0;
      r_mul_l  <= 1'b0;
      r_mul_h  <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_off    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.valid) begin
            r_a     <= bus.crs1;
            r_b     <= bus.crs2;
            r_pw    <= bus.pw;
            r_clmul <= bus.clmul;
            r_mul_l <= bus.mul_l;
            r_mul_h <= bus.mul_h;
            r_acc   <= '0;
            r_cnt   <= steps(bus.pw, BPC);
            r_off   <= '0;
          end
        end
        BUSY: begin
          if (!bus.valid) begin
            r_acc <= '0;
            r_cnt <= '0;
          end else begin
            r_acc <= w_acc;
            r_cnt <= r_cnt - 6'd1;
            r_off <= r_off + 5'(BPC);
            r_b   <= r_b >> BPC;
            if (w_last) r_result <= w_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready  = (r_state == DONE);
  assign bus.result = r_result;

endmodule
